// File: rtl/series_tx_pkg.sv
// Shared types and constants for the series_tx serialiser.
// SERIES_TX_PREAMBLE_EN adds the PREAMBLE state to the state encoding.
package series_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
`ifdef SERIES_TX_PREAMBLE_EN
    ST_PREAMBLE = 2'd1,
`endif
    ST_SHIFT    = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam logic [2:0] PREAMBLE     = 3'b101;
  localparam int         PREAMBLE_LEN = 3;

  // Preamble is sent MSB first; idx counts preamble cycles from 0.
  function automatic logic pre_bit(input logic [1:0] idx);
    return PREAMBLE[2'd2 - idx];
  endfunction

endpackage

// File: rtl/series_tx_if.sv
// Word-in / bit-out bundle between a producer and series_tx.
interface series_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_bit, out_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/series_tx_piso.sv
// Parallel-load, shift-left register exposing its MSB.
module series_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  // Load has priority over shift; zeros enter at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/series_tx.sv
// MSB-first word serialiser with optional 1,0,1 preamble and inter-word gap.
// Optional feature macro: SERIES_TX_PREAMBLE_EN.
module series_tx
  import series_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic        clk,
  input logic        rst,
  series_tx_if.slave bus
);

  localparam int CNT_MAX0 = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CNT_MAX  = (CNT_MAX0 > PREAMBLE_LEN) ? CNT_MAX0 : PREAMBLE_LEN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DONE_BIT = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CNT_W-1:0] LAST_PRE = CNT_W'(PREAMBLE_LEN - 1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_out_bit, w_bit_nx;
  logic             r_out_valid, w_valid_nx;
  logic             r_done, w_done_nx;
  logic             w_load, w_shift, w_msb;
  logic [WIDTH-1:0] w_load_data;

  series_piso #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_msb)
  );

  // Next-state, counter and next-output decode; outputs are registered below.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_bit_nx    = IDLE_LEVEL;
    w_valid_nx  = 1'b0;
    w_done_nx   = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_data = bus.in_data;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_load     = 1'b1;
          w_cnt_nx   = {CNT_W{1'b0}};
          w_valid_nx = 1'b1;
`ifdef SERIES_TX_PREAMBLE_EN
          w_state_nx  = ST_PREAMBLE;
          w_bit_nx    = PREAMBLE[2];
          w_load_data = bus.in_data;
`else
          // MSB goes straight to out_bit, so the register holds the rest.
          w_state_nx  = ST_SHIFT;
          w_bit_nx    = bus.in_data[WIDTH-1];
          w_load_data = {bus.in_data[WIDTH-2:0], 1'b0};
`endif
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
`ifdef SERIES_TX_PREAMBLE_EN
      ST_PREAMBLE: begin
        w_valid_nx = 1'b1;
        if (r_cnt == LAST_PRE) begin
          w_state_nx = ST_SHIFT;
          w_cnt_nx   = {CNT_W{1'b0}};
          w_bit_nx   = w_msb;
          w_shift    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
          w_bit_nx = pre_bit(r_cnt[1:0] + 2'd1);
        end
      end
`endif
      ST_SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_cnt_nx   = {CNT_W{1'b0}};
          w_state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          w_cnt_nx   = r_cnt + CNT_ONE;
          w_valid_nx = 1'b1;
          w_bit_nx   = w_msb;
          w_shift    = 1'b1;
          w_done_nx  = (r_cnt == DONE_BIT);
        end
      end
      ST_GAP: begin
        if (r_cnt == LAST_GAP) begin
          w_cnt_nx   = {CNT_W{1'b0}};
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and output flops; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_out_bit   <= IDLE_LEVEL;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_out_bit   <= w_bit_nx;
      r_out_valid <= w_valid_nx;
      r_done      <= w_done_nx;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_bit   = r_out_bit;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_series_tx.sv
// Directed scoreboard bench for series_tx (WIDTH=8/GAP=1 and WIDTH=2/GAP=0 instances).
// Expectations follow SERIES_TX_PREAMBLE_EN when it is defined.
module tb_series_tx;

`ifdef SERIES_TX_PREAMBLE_EN
  localparam int PRE = 3;
`else
  localparam int PRE = 0;
`endif
  localparam int PB = 1 + PRE + 2;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  bit   mon_en;
  int   total;
  int   bad;
  exp_t sb_a[$];
  exp_t sb_b[$];

  series_tx_if #(.WIDTH(8)) bus_a ();
  series_tx_if #(.WIDTH(2)) bus_b ();

  series_tx #(.WIDTH(8), .GAP(1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  series_tx #(.WIDTH(2), .GAP(0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    logic [2:0] pat;
    pat = 3'b101;
    for (int i = PRE - 1; i >= 0; i--) sb_a.push_back('{b: pat[i], last: 1'b0});
    for (int i = 7; i >= 0; i--) sb_a.push_back('{b: d[i], last: (i == 0)});
  endtask

  task automatic push_b(input logic [1:0] d);
    logic [2:0] pat;
    pat = 3'b101;
    for (int i = PRE - 1; i >= 0; i--) sb_b.push_back('{b: pat[i], last: 1'b0});
    for (int i = 1; i >= 0; i--) sb_b.push_back('{b: d[i], last: (i == 0)});
  endtask

  // Scoreboard for the 8-bit instance: every valid cycle pops one expected bit.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus_a.out_valid === 1'b1) begin
        if (sb_a.size() == 0) begin
          chk1("a_unexpected_valid", bus_a.out_valid, 1'b0);
        end else begin
          e = sb_a.pop_front();
          chk1("a_bit", bus_a.out_bit, e.b);
          chk1("a_done", bus_a.done, e.last);
        end
      end else begin
        chk1("a_valid_known", bus_a.out_valid, 1'b0);
        chk1("a_idle_bit", bus_a.out_bit, 1'b0);
        chk1("a_idle_done", bus_a.done, 1'b0);
      end
    end
  end

  // Scoreboard for the 2-bit instance, idle level high.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus_b.out_valid === 1'b1) begin
        if (sb_b.size() == 0) begin
          chk1("b_unexpected_valid", bus_b.out_valid, 1'b0);
        end else begin
          e = sb_b.pop_front();
          chk1("b_bit", bus_b.out_bit, e.b);
          chk1("b_done", bus_b.done, e.last);
        end
      end else begin
        chk1("b_valid_known", bus_b.out_valid, 1'b0);
        chk1("b_idle_bit", bus_b.out_bit, 1'b1);
        chk1("b_idle_done", bus_b.done, 1'b0);
      end
    end
  end

  initial begin
    logic [7:0] d;
    total = 0;
    bad   = 0;
    mon_en = 1'b0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'h00;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 2'b00;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk1("rst_ready", bus_a.in_ready, 1'b1);
    chk1("rst_busy", bus_a.busy, 1'b0);
    chk1("rst_valid", bus_a.out_valid, 1'b0);
    chk1("rst_bit", bus_a.out_bit, 1'b0);
    chk1("rst_done", bus_a.done, 1'b0);
    chk1("rst_b_bit", bus_b.out_bit, 1'b1);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single word 8'hA5, handshake timing
    tick();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hA5;
    push_a(8'hA5);
    @(negedge clk);
    chk1("a5_ready_c0", bus_a.in_ready, 1'b1);
    for (int k = 1; k <= 10 + PRE; k++) begin
      tick();
      if (k == 1) bus_a.in_valid = 1'b0;
      @(negedge clk);
      chk1("a5_ready", bus_a.in_ready, (k == 10 + PRE));
      chk1("a5_busy", bus_a.busy, (k != 10 + PRE));
    end

    // Back-to-back with in_valid held high: 8'hFF then 8'h00
    tick();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    push_a(8'hFF);
    for (int k = 1; k <= 20 + 2 * PRE; k++) begin
      tick();
      if (k == 1) begin
        bus_a.in_data = 8'h00;
        push_a(8'h00);
      end
      if (k == 11 + PRE) bus_a.in_valid = 1'b0;
      @(negedge clk);
      if (k == 9 + PRE) begin
        chk1("b2b_gap_bit", bus_a.out_bit, 1'b0);
        chk1("b2b_gap_valid", bus_a.out_valid, 1'b0);
      end
      if (k == 10 + PRE) chk1("b2b_ready", bus_a.in_ready, 1'b1);
      if (k == 11 + PRE) begin
        chk1("b2b_first_valid", bus_a.out_valid, 1'b1);
        chk1("b2b_first_bit", bus_a.out_bit, (PRE > 0));
      end
      if (k == 20 + 2 * PRE) chk1("b2b_idle", bus_a.in_ready, 1'b1);
    end

    // Reset mid-word, then a new word right after
    tick();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hA5;
    push_a(8'hA5);
    for (int k = 1; k <= 15 + PRE; k++) begin
      tick();
      if (k == 1) bus_a.in_valid = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        sb_a.delete();
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h3C;
        push_a(8'h3C);
      end
      if (k == 6) bus_a.in_valid = 1'b0;
      @(negedge clk);
      if (k == 5) begin
        chk1("abort_bit", bus_a.out_bit, 1'b0);
        chk1("abort_valid", bus_a.out_valid, 1'b0);
        chk1("abort_done", bus_a.done, 1'b0);
        chk1("abort_ready", bus_a.in_ready, 1'b1);
      end
      if (k == 6) chk1("restart_valid", bus_a.out_valid, 1'b1);
      if (k == 15 + PRE) chk1("restart_idle", bus_a.in_ready, 1'b1);
    end

    // Reset wins over a simultaneous in_valid
    tick();
    rst = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    tick();
    rst = 1'b0;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk1("rstpri_busy", bus_a.busy, 1'b0);
    chk1("rstpri_ready", bus_a.in_ready, 1'b1);
    tick();
    @(negedge clk);
    chk1("rstpri_busy2", bus_a.busy, 1'b0);

    // in_valid toggling and in_data changing while the word is in flight
    tick();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h96;
    push_a(8'h96);
    for (int k = 1; k <= 10 + PRE; k++) begin
      tick();
      bus_a.in_valid = (k < 9 + PRE) ? k[0] : 1'b0;
      bus_a.in_data  = 8'($urandom);
      @(negedge clk);
    end
    chk1("toggle_idle", bus_a.in_ready, 1'b1);

    // A few random words
    for (int w = 0; w < 4; w++) begin
      d = 8'($urandom);
      tick();
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = d;
      push_a(d);
      for (int k = 1; k <= 10 + PRE; k++) begin
        tick();
        if (k == 1) bus_a.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chkn("a_sb_empty", sb_a.size(), 0);

    // WIDTH=2, GAP=0, continuous in_valid with 2'b10
    for (int k = 0; k < 4 * PB; k++) begin
      tick();
      bus_b.in_valid = (k <= 3 * PB);
      bus_b.in_data  = 2'b10;
      if ((k % PB == 0) && (k <= 3 * PB)) push_b(2'b10);
      @(negedge clk);
      chk1("b_valid_pat", bus_b.out_valid, (k % PB != 0));
      chk1("b_ready_pat", bus_b.in_ready, (k % PB == 0));
    end
    tick();
    @(negedge clk);
    chk1("b_end_valid", bus_b.out_valid, 1'b0);
    chk1("b_end_ready", bus_b.in_ready, 1'b1);
    chkn("b_sb_empty", sb_b.size(), 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/series_tx.md
SERIES_TX -- requirements
Module: series_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word length in bits (>=2).
REQ-002 Parameter GAP, default 1: idle cycles inserted after each word (>=0).
REQ-003 Parameter IDLE_LEVEL, default 1'b0: out_bit level when no bit is being sent.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer offers in_data.
REQ-007 in_data  input  WIDTH  parallel word to serialise.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 out_bit  output  1  registered serial bit stream, MSB first.
REQ-010 out_valid  output  1  out_bit carries a preamble or data bit this cycle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse while the last data bit of a word is on out_bit.

Function
REQ-013 FSM states: IDLE, PREAMBLE (only with the macro in REQ-027), SHIFT, GAP.
REQ-014 in_ready SHALL equal (state==IDLE); a word is accepted on the edge where in_valid & in_ready.
REQ-015 Accepted word is captured into an internal shift register; later in_data changes have no effect.
REQ-016 in_valid outside IDLE is ignored; no word is queued.
REQ-017 Latency: first transmitted bit on out_bit in the cycle after acceptance.
REQ-018 SHIFT: WIDTH cycles, bit WIDTH-1 first down to bit 0, out_valid=1.
REQ-019 done=1 exactly in the cycle bit 0 is on out_bit; 0 otherwise.
REQ-020 After SHIFT: GAP cycles in GAP state (out_bit=IDLE_LEVEL, out_valid=0), then IDLE; GAP=0 goes straight to IDLE.
REQ-021 Back-to-back word period: 1 + PRE + WIDTH + GAP cycles (PRE = 3 with the macro, else 0).
REQ-022 In IDLE and GAP, out_bit=IDLE_LEVEL, out_valid=0, done=0.
REQ-023 Bit counter wraps to 0 on leaving SHIFT and PREAMBLE; no count survives to the next word.

Reset
REQ-024 On rst at a posedge: state=IDLE, out_bit=IDLE_LEVEL, out_valid=0, done=0, busy=0, counters=0, shift register=0.
REQ-025 rst mid-word aborts the word: no further bits, no done pulse; in_ready=1 the cycle after reset deasserts.
REQ-026 rst has priority over a simultaneous in_valid; that word is not accepted.

Configuration
REQ-027 Macro SERIES_TX_PREAMBLE_EN: when defined, each word is preceded by PREAMBLE state sending 1,0,1 (out_valid=1), then SHIFT.
REQ-028 Without SERIES_TX_PREAMBLE_EN: PREAMBLE state and logic absent; acceptance goes directly to SHIFT.
REQ-029 done timing relative to the last data bit is identical in both builds.

Structure
REQ-030 Package series_pkg holds: state enum type, preamble constant 3'b101, PREAMBLE_LEN=3.
REQ-031 One sub-module, series_piso: WIDTH-bit parallel-load, shift-left register with load, shift and MSB output.
REQ-032 FSM, counters and output registers live in series_tx; out_bit, out_valid, done are flop outputs.

Verification
REQ-033 WIDTH=8, GAP=1, no macro: accept 8'hA5 at cycle 0 -> out_bit 1,0,1,0,0,1,0,1 on cycles 1-8, done only at cycle 8, in_ready 0 on cycles 1-9, 1 at cycle 10.
REQ-034 in_valid held high with 8'hFF then 8'h00 -> second word first bit at cycle 11; out_bit=0 at cycle 9.
REQ-035 rst asserted at cycle 4 during 8'hA5 -> cycle 5 out_bit=0, out_valid=0, no done; new word accepted at cycle 5 starts at cycle 6.
REQ-036 in_valid toggling during SHIFT with changing in_data -> transmitted bits match only the originally accepted word.
REQ-037 Macro defined, send 8'h00 -> out_bit 1,0,1 then eight 0s, out_valid high 11 cycles, done at cycle 11.
REQ-038 GAP=0, WIDTH=2, continuous in_valid with 2'b10 -> period 3 cycles, out_valid pattern 0,1,1 repeating.
